// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Responder side of the ALU start/done divide handshake.
module seq_divider #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] dividend,
    input  logic [BIT_WIDTH-1:0] divisor,
    output logic [BIT_WIDTH-1:0] quotient,
    output logic [BIT_WIDTH-1:0] remainder,
    output logic                 done,
    output logic                 active
);

    localparam int CW = $clog2(BIT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BIT_WIDTH-1:0] p, p_n;
    logic [BIT_WIDTH-1:0] q, q_n;
    logic [BIT_WIDTH-1:0] dvs, dvs_n;
    logic [BIT_WIDTH-1:0] quo_n, rem_n;
    logic [BIT_WIDTH:0]   p_sh;
    logic [BIT_WIDTH-1:0] p_sub;
    logic                 fits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            p         <= '0;
            q         <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            p         <= p_n;
            q         <= q_n;
            dvs       <= dvs_n;
            quotient  <= quo_n;
            remainder <= rem_n;
            done      <= (state_n == DONE);
            active    <= (state_n == BUSY);
        end
    end

    // Partial remainder is one bit wider than the divisor so an MSB-set
    // divisor still compares correctly; the difference always fits in BIT_WIDTH.
    always_comb begin
        p_sh  = {p, q[BIT_WIDTH-1]};
        fits  = (p_sh >= {1'b0, dvs});
        p_sub = p_sh[BIT_WIDTH-1:0] - dvs;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        p_n     = p;
        q_n     = q;
        dvs_n   = dvs;
        quo_n   = quotient;
        rem_n   = remainder;
        unique case (state)
            IDLE: begin
                if (start) begin
                    dvs_n = divisor;
                    q_n   = dividend;
                    p_n   = '0;
                    if (divisor == '0) begin
                        state_n = DONE;
                        quo_n   = '1;
                        rem_n   = dividend;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = CW'(BIT_WIDTH);
                    end
                end
            end
            BUSY: begin
                if (!start) begin
                    state_n = IDLE;
                end else begin
                    if (fits) begin
                        p_n = p_sub;
                        q_n = {q[BIT_WIDTH-2:0], 1'b1};
                    end else begin
                        p_n = p_sh[BIT_WIDTH-1:0];
                        q_n = {q[BIT_WIDTH-2:0], 1'b0};
                    end
                    cnt_n = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_n = DONE;
                        quo_n   = q_n;
                        rem_n   = p_n;
                    end
                end
            end
            DONE: begin
                if (!start) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an
// arithmetic reference model (a/b, a%b, divide-by-zero rule).
module tb_seq_divider;

    localparam int W = 32;
    localparam logic [W-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         active;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] last_q, last_r;

    seq_divider #(.BIT_WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .done(done),
        .active(active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        return (b == 0) ? ONES : a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    // One full handshake: accept, wait for done, hold start, release.
    task automatic divide(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit scramble);
        int n;
        int act;
        int exp_lat;
        logic [W-1:0] eq, er;
        eq = ref_q(a, b);
        er = ref_r(a, b);
        exp_lat = (b == 0) ? 0 : W;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        n = 0;
        act = 0;
        while (!done && n < W + 8) begin
            if (active) act++;
            check("exclusive", {63'd0, done & active}, 64'd0);
            if (scramble) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, exp_lat);
        check("active_cycles", act, exp_lat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_done", {62'd0, done, active}, 64'd2);
            check("hold_q", quotient, eq);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("release", {62'd0, done, active}, 64'd0);
        check("idle_q", quotient, eq);
        check("idle_r", remainder, er);
        last_q = eq;
        last_r = er;
    endtask

    function automatic logic [W-1:0] rand_val(input int mode);
        logic [W-1:0] v;
        v = $urandom;
        case (mode)
            0: v = '0;
            1: v = v & 32'hF;
            2: v = v | 32'h8000_0000;
            3: v = v & 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        last_q   = '0;
        last_r   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", quotient, 0);
        check("reset_r", remainder, 0);
        check("reset_flags", {62'd0, done, active}, 0);
        @(negedge clk);
        reset = 1'b0;

        divide(32'd100, 32'd7, 0, 1'b0);
        divide(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        divide(32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
        divide(32'd5, 32'd9, 0, 1'b0);
        divide(32'd1234, 32'd0, 0, 1'b0);

        // Abort mid-divide: result registers keep the previous divide.
        @(negedge clk);
        dividend = 32'd999;
        divisor  = 32'd3;
        start    = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_flags", {62'd0, done, active}, 0);
        check("abort_q", quotient, last_q);
        check("abort_r", remainder, last_r);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_nodone", {63'd0, done}, 0);
        end

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("areset_q", quotient, 0);
        check("areset_r", remainder, 0);
        check("areset_flags", {62'd0, done, active}, 0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back with operand scramble and a long DONE hold.
        divide(32'd100, 32'd7, 0, 1'b0);
        divide(32'd81, 32'd9, 5, 1'b1);

        for (int i = 0; i < 40; i++) begin
            divide(rand_val($urandom_range(1, 4)),
                   rand_val($urandom_range(0, 4)),
                   $urandom_range(0, 2), $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
